// File: rtl/fetch_instr_buff_ctrl_pkg.sv
// Fetch tag layout and pack/unpack helpers shared by the fetch tracker and the fetch-to-wavepool flop stage.
// Tag packing is {first, wfid[5:0], pc[31:0]}.
package fetch_instr_buff_ctrl_pkg;

  localparam int FETCH_TAG_W   = 39;
  localparam int TAG_FIRST_BIT = 38;
  localparam int TAG_WFID_HI   = 37;
  localparam int TAG_WFID_LO   = 32;
  localparam int TAG_PC_HI     = 31;
  localparam int TAG_PC_LO     = 0;
  localparam int WFID_W        = 6;
  localparam int PC_W          = 32;

  typedef logic [FETCH_TAG_W-1:0] fetch_tag_t;

  function automatic fetch_tag_t pack_tag(input logic first,
                                          input logic [WFID_W-1:0] wfid,
                                          input logic [PC_W-1:0] pc);
    return {first, wfid, pc};
  endfunction

  function automatic logic tag_first(input fetch_tag_t tag);
    return tag[TAG_FIRST_BIT];
  endfunction

  function automatic logic [WFID_W-1:0] tag_wfid(input fetch_tag_t tag);
    return tag[TAG_WFID_HI:TAG_WFID_LO];
  endfunction

  function automatic logic [PC_W-1:0] tag_pc(input fetch_tag_t tag);
    return tag[TAG_PC_HI:TAG_PC_LO];
  endfunction

endpackage

// File: rtl/fetch_instr_buff_ctrl_if.sv
// Bundle of fetch-request, instruction-memory, flush and delivery signals around the fetch tracker.
// The slave modport is the tracker's view; master is the surrounding pipeline's view.
interface fetch_instr_buff_ctrl_if #(
  parameter int OUTSTANDING = 4
);
  import fetch_instr_buff_ctrl_pkg::*;

  localparam int CNT_W = $clog2(OUTSTANDING) + 1;

  logic              fetch_valid;
  logic [WFID_W-1:0] fetch_wfid;
  logic [PC_W-1:0]   fetch_pc;
  logic              fetch_first;
  logic              fetch_ready;
  logic              mem_rd_en;
  logic [PC_W-1:0]   mem_addr;
  fetch_tag_t        mem_tag;
  logic              mem_ack;
  fetch_tag_t        mem_tag_resp;
  logic [31:0]       mem_data;
  logic              wf_flush;
  logic [WFID_W-1:0] wf_flush_wfid;
  fetch_tag_t        buff_tag;
  logic [31:0]       buff_instr;
  logic              buff_ack;
  logic              tag_err;
  logic [CNT_W-1:0]  outstanding_cnt;

  modport slave (
    input  fetch_valid, fetch_wfid, fetch_pc, fetch_first,
    input  mem_ack, mem_tag_resp, mem_data, wf_flush, wf_flush_wfid,
    output fetch_ready, mem_rd_en, mem_addr, mem_tag,
    output buff_tag, buff_instr, buff_ack, tag_err, outstanding_cnt
  );

  modport master (
    output fetch_valid, fetch_wfid, fetch_pc, fetch_first,
    output mem_ack, mem_tag_resp, mem_data, wf_flush, wf_flush_wfid,
    input  fetch_ready, mem_rd_en, mem_addr, mem_tag,
    input  buff_tag, buff_instr, buff_ack, tag_err, outstanding_cnt
  );

endinterface

// File: rtl/fetch_instr_buff_ctrl_tag_fifo.sv
// In-order tag FIFO of {tag, squash} entries with parallel wfid squash; head is combinational from state.
// Caller must not push when full nor pop when empty; count updates on the next edge.
module fetch_tag_fifo
  import fetch_instr_buff_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  fetch_tag_t        push_tag_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [WFID_W-1:0] flush_wfid_i,
  output fetch_tag_t        head_tag_o,
  output logic              head_squash_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  fetch_tag_t       tag_q [DEPTH];
  logic [DEPTH-1:0] squash_q, squash_d;
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    valid    = '0;
    squash_d = squash_q;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, PTR_W'(i) - rd_ptr_q} < count_q;
      if (flush_i && valid[i] && (tag_wfid(tag_q[i]) == flush_wfid_i)) squash_d[i] = 1'b1;
    end
    // A same-cycle push is younger than the flush and must survive it.
    if (push_i) squash_d[wr_ptr_q] = 1'b0;
  end

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
      squash_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        tag_q[wr_ptr_q] <= push_tag_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      squash_q <= squash_d;
      count_q  <= count_d;
    end
  end

  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign count_o       = count_q;
  assign head_tag_o    = tag_q[rd_ptr_q];
  // Flush is seen before a same-cycle pop so an acked matching head is suppressed.
  assign head_squash_o = squash_q[rd_ptr_q] |
                         (flush_i && !empty_o && (tag_wfid(tag_q[rd_ptr_q]) == flush_wfid_i));

endmodule

// File: rtl/fetch_instr_buff_ctrl.sv
// Tracks in-order instruction-fetch reads and delivers tagged instructions; accept->mem_rd_en and ack->buff_ack are 1 cycle.
// fetch_ready drops while OUTSTANDING reads are in flight (no same-cycle pop bypass); responses cannot be stalled.
module fetch_instr_buff_ctrl
  import fetch_instr_buff_ctrl_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input logic                   clk,
  input logic                   rst,
  fetch_instr_buff_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(OUTSTANDING) + 1;

  fetch_tag_t       req_tag, head_tag;
  logic             head_squash, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             accept, pop, tag_match, deliver, proto_err;

  logic             mem_rd_en_q, mem_rd_en_d;
  logic [PC_W-1:0]  mem_addr_q, mem_addr_d;
  fetch_tag_t       mem_tag_q, mem_tag_d;
  logic             buff_ack_q, buff_ack_d;
  fetch_tag_t       buff_tag_q, buff_tag_d;
  logic [31:0]      buff_instr_q, buff_instr_d;
  logic             tag_err_q, tag_err_d;

  assign req_tag   = pack_tag(bus.fetch_first, bus.fetch_wfid, bus.fetch_pc);
  assign accept    = bus.fetch_valid && !fifo_full;
  assign pop       = bus.mem_ack && !fifo_empty;
  assign tag_match = (head_tag == bus.mem_tag_resp);
  assign deliver   = pop && !head_squash && tag_match;
  // Squashed heads are dropped silently even if the returned tag disagrees.
  assign proto_err = bus.mem_ack && (fifo_empty || (!head_squash && !tag_match));

  fetch_tag_fifo #(.DEPTH(OUTSTANDING)) u_tag_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (accept),
    .push_tag_i   (req_tag),
    .pop_i        (pop),
    .flush_i      (bus.wf_flush),
    .flush_wfid_i (bus.wf_flush_wfid),
    .head_tag_o   (head_tag),
    .head_squash_o(head_squash),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  always_comb begin
    mem_rd_en_d  = accept;
    mem_addr_d   = accept ? bus.fetch_pc : mem_addr_q;
    mem_tag_d    = accept ? req_tag : mem_tag_q;
    buff_ack_d   = deliver;
    buff_tag_d   = deliver ? head_tag : buff_tag_q;
    buff_instr_d = deliver ? bus.mem_data : buff_instr_q;
    tag_err_d    = tag_err_q | proto_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_tag_q    <= '0;
      buff_ack_q   <= 1'b0;
      buff_tag_q   <= '0;
      buff_instr_q <= '0;
      tag_err_q    <= 1'b0;
    end else begin
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_tag_q    <= mem_tag_d;
      buff_ack_q   <= buff_ack_d;
      buff_tag_q   <= buff_tag_d;
      buff_instr_q <= buff_instr_d;
      tag_err_q    <= tag_err_d;
    end
  end

  assign bus.fetch_ready     = !fifo_full;
  assign bus.mem_rd_en       = mem_rd_en_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_tag         = mem_tag_q;
  assign bus.buff_ack        = buff_ack_q;
  assign bus.buff_tag        = buff_tag_q;
  assign bus.buff_instr      = buff_instr_q;
  assign bus.tag_err         = tag_err_q;
  assign bus.outstanding_cnt = fifo_count;

endmodule
